spi_reg_bridge: RTL
===================

Name: spi_reg_bridge

Overview:
- SPI slave front end that turns serial host frames into parallel register-bus writes and reads for gpio_reg and other register blocks on the same bus.
- Drives addr/wdata/we into the register block. Samples the block's rdata_out and shifts it back to the host on MISO.
- The SPI pins are asynchronous to clk. All pin inputs are synchronised and edge-detected in the clk domain.

Parameters:
- ADDR_W, 4, register address width; must be ≤ 7 because it occupies the low bits of the command byte.
- DATA_W, 8, register data width, which is also the data-phase bit count.
- SYNC_STAGES, 2, flop count in each pin synchroniser; minimum 2.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- sclk  input  1  SPI clock, mode 0 (CPOL=0, CPHA=0), async
- cs_n  input  1  SPI chip select, active low, async
- mosi  input  1  SPI data in, MSB first, async
- miso  output  1  SPI data out, MSB first
- rdata_in  input  DATA_W  read data from the register block, combinational on addr
- addr  output  ADDR_W  register address
- wdata  output  DATA_W  write data
- we  output  1  one-cycle write strobe
- busy  output  1  high while a frame is in progress
- frame_abort  output  1  one-cycle pulse when a frame is cut short

Behaviour:
- Reset values: addr=0, wdata=0, we=0, miso=0, busy=0, frame_abort=0, state=IDLE, bit counter=0.
- Synchronisation: sclk, cs_n and mosi each pass through SYNC_STAGES flops. Event detection compares the last sync stage with one further history flop.
  - sclk rise = sample point; sclk fall = MISO update point.
  - cs_n fall = frame start; cs_n rise = frame end.
- Host timing constraint: sclk high and low phases each ≥ 3 clk periods.
- Frame format: 8-bit command, then DATA_W data bits.
  - Command bit7 = RW (1 = write). Bits 6..ADDR_W are ignored. Bits ADDR_W-1..0 = address.
- States:
  - IDLE: busy=0. On cs_n fall, clear bit counter and go to CMD.
  - CMD: shift mosi on each sclk rise. After the 8th rise:
    - latch addr from the command;
    - latch RW internally;
    - go to LOAD.
  - LOAD: exactly one clk cycle, so rdata_in settles on the new addr. Capture rdata_in into the TX shift register. Go to DATA.
  - DATA: on each sclk rise, shift mosi into the RX shift register. On each sclk fall, advance miso to the next TX bit.
    - TX MSB is presented on miso on entry to DATA, ready for the host's first data-phase rise.
    - After DATA_W rises: if RW=1, set wdata to the RX value and pulse we for exactly one clk, in the same cycle as the wdata update. If RW=0, no we.
    - Go to DONE.
  - DONE: ignore further sclk edges; miso held 0. On cs_n rise, go to IDLE.
- busy = (state != IDLE).
- Abort: cs_n rise in CMD, LOAD or DATA produces:
  - a frame_abort pulse for 1 clk;
  - no we;
  - addr and wdata unchanged except that addr keeps any value already latched in CMD;
  - return to IDLE.
- Simultaneous events:
  - cs_n rise with the final data-bit sclk rise in the same clk: treated as abort; no we.
  - cs_n fall while in DONE, with no rise seen: not possible after sync; the ordering of synchronised cs_n events is preserved.
- miso output:
  - In IDLE and DONE, miso is 0.
  - In CMD, miso is 0.
  - No tristate; an external buffer is gated by cs_n.
- addr and wdata hold their values between frames. The register block sees stable addr/wdata for the whole we cycle and afterwards.
- Reset asserted mid-frame: all outputs go to reset values immediately. The frame is discarded and no we is issued. After rst_n release, the bridge waits in IDLE for a fresh cs_n fall, ignoring a cs_n that is already low.
- Latency: we asserts SYNC_STAGES+2 clk cycles after the pin-level 16th sclk rise (±1 clk for sampling phase).

Test Plan:
- Write frame cmd=0x83, data=0xA5 at sclk = clk/8 -> addr=0x3, wdata=0xA5, we high for exactly 1 clk within SYNC_STAGES+3 clk of the last rise; downstream gpio_out=0xA5.
- Read frame cmd=0x03, data bits 0x00, with rdata_in=0x5C on addr 3 -> miso shifts 0,1,0,1,1,1,0,0 across the data phase; no we; wdata unchanged.
- Abort: cs_n rises after 12 of 16 bits of write 0x81/0xFF -> frame_abort 1-clk pulse, we never asserts, wdata keeps its prior value; the next full frame 0x81/0x0F writes 0x0F correctly.
- Over-clocked frame: 20 sclk rises in a write frame 0x82/0x3C -> single we at bit 16 with wdata=0x3C; extra bits ignored; busy=1 until cs_n rises.
- Reset mid-frame: assert rst_n low after 10 bits -> all outputs 0 immediately. Release with cs_n still low and finish the clocks -> no we. A new frame after cs_n toggles high then low works normally.
- Back-to-back writes with 2-clk cs_n high gap: 0x81/0x11 then 0x82/0x22 -> two we pulses with (addr,wdata) = (1,0x11) then (2,0x22); busy drops for ≥1 clk between the frames.

Source files
------------

// File: rtl/spi_reg_bridge.sv
// SPI mode-0 slave that turns host frames (8-bit command + DATA_W data bits)
// into register-bus writes, and shifts register read data back out on MISO.
// All SPI pins are treated as asynchronous and are synchronised into clk.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | no frame; waiting for a cs_n fall
// CMD    | shifting in the 8 command bits (RW, ignored bits, address)
// LOAD   | one cycle for rdata_in to settle on the new addr, then capture
// DATA   | shifting data in on sclk rise, data out on sclk fall
// DONE   | frame complete; extra sclk edges ignored until cs_n rises
module spi_reg_bridge #(
    parameter int ADDR_W      = 4,   // must be <= 7 (sits in the command byte)
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2    // minimum 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sclk,
    input  logic              cs_n,
    input  logic              mosi,
    output logic              miso,
    input  logic [DATA_W-1:0] rdata_in,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wdata,
    output logic              we,
    output logic              busy,
    output logic              frame_abort
);

    localparam int MAX_BITS = (DATA_W > 8) ? DATA_W : 8;
    localparam int CNT_W    = $clog2(MAX_BITS + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_LOAD,
        S_DATA,
        S_DONE
    } state_t;

    state_t state;

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sclk_hist;
    logic                   cs_hist;

    logic sclk_s;
    logic cs_s;
    logic mosi_s;
    logic sclk_rise;
    logic sclk_fall;
    logic cs_fall;
    logic cs_rise;

    logic [CNT_W-1:0]  bit_cnt;
    logic [6:0]        cmd_sr;
    logic [7:0]        cmd_next;
    logic [DATA_W-2:0] rx_sr;
    logic [DATA_W-1:0] rx_next;
    logic [DATA_W-2:0] tx_sr;
    logic              rw;

    // Pin synchronisers plus one history flop for edge detection. cs_n resets
    // to 0 so a chip select that is already low at reset release is not
    // mistaken for a frame start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync <= '0;
            cs_sync   <= '0;
            mosi_sync <= '0;
            sclk_hist <= 1'b0;
            cs_hist   <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            sclk_hist <= sclk_sync[SYNC_STAGES-1];
            cs_hist   <= cs_sync[SYNC_STAGES-1];
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_hist;
    assign sclk_fall = ~sclk_s & sclk_hist;
    assign cs_fall   = ~cs_s & cs_hist;
    assign cs_rise   = cs_s & ~cs_hist;

    assign cmd_next  = {cmd_sr, mosi_s};
    assign rx_next   = {rx_sr, mosi_s};
    assign busy      = (state != S_IDLE);

    // Frame sequencer with registered bus and MISO outputs; cs_n rise takes
    // priority over any sclk edge in the same cycle, so a late final bit aborts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            bit_cnt     <= '0;
            cmd_sr      <= '0;
            rx_sr       <= '0;
            tx_sr       <= '0;
            rw          <= 1'b0;
            addr        <= '0;
            wdata       <= '0;
            we          <= 1'b0;
            miso        <= 1'b0;
            frame_abort <= 1'b0;
        end else begin
            we          <= 1'b0;
            frame_abort <= 1'b0;
            case (state)
                S_IDLE: begin
                    miso <= 1'b0;
                    if (cs_fall) begin
                        bit_cnt <= '0;
                        state   <= S_CMD;
                    end
                end
                S_CMD: begin
                    miso <= 1'b0;
                    if (cs_rise) begin
                        frame_abort <= 1'b1;
                        state       <= S_IDLE;
                    end else if (sclk_rise) begin
                        cmd_sr <= cmd_next[6:0];
                        if (bit_cnt == CNT_W'(7)) begin
                            addr    <= cmd_next[ADDR_W-1:0];
                            rw      <= cmd_next[7];
                            bit_cnt <= '0;
                            state   <= S_LOAD;
                        end else begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end
                end
                S_LOAD: begin
                    if (cs_rise) begin
                        frame_abort <= 1'b1;
                        miso        <= 1'b0;
                        state       <= S_IDLE;
                    end else begin
                        tx_sr <= rdata_in[DATA_W-2:0];
                        miso  <= rdata_in[DATA_W-1];
                        state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (cs_rise) begin
                        frame_abort <= 1'b1;
                        miso        <= 1'b0;
                        state       <= S_IDLE;
                    end else if (sclk_rise) begin
                        rx_sr <= rx_next[DATA_W-2:0];
                        if (bit_cnt == CNT_W'(DATA_W - 1)) begin
                            if (rw) begin
                                wdata <= rx_next;
                                we    <= 1'b1;
                            end
                            miso  <= 1'b0;
                            state <= S_DONE;
                        end else begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end else if (sclk_fall && (bit_cnt != '0)) begin
                        // The fall trailing the last command bit arrives after
                        // the MSB is already out; only falls after a data rise
                        // advance the shift register.
                        miso  <= tx_sr[DATA_W-2];
                        tx_sr <= tx_sr << 1;
                    end
                end
                S_DONE: begin
                    miso <= 1'b0;
                    if (cs_rise) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    miso  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
